// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, single-outstanding imem req/ack, 2-entry instruction FIFO.
// Optional MIPS delay-slot behaviour is enabled by defining FETCH_DELAY_SLOT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall_D,
  input  logic        PCSrc_D,
  input  logic [31:0] pc_target_D,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_F,
  output logic [31:0] npc_F,
  output logic        fetch_busy
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DROP} state_t;

  state_t           r_state, w_state_nx;
  logic [31:0]      r_pc, w_pc_nx, w_pc_inc;
  logic [31:0]      r_drop_addr, w_drop_nx;
  logic [1:0][31:0] r_instr, r_npc;
  logic [1:0]       r_count;
  logic             w_redir, w_pop, w_push, w_flush, w_ack, w_wr;
`ifdef FETCH_DELAY_SLOT_EN
  logic             r_pend, w_pend_nx;
  logic [31:0]      r_tgt, w_tgt_nx;
`endif

  assign w_redir  = PCSrc_D & ~Stall_D;
  assign w_pop    = ~Stall_D & (r_count != 2'd0);
  assign w_pc_inc = r_pc + 32'd4;
  // DROP keeps presenting the abandoned address until memory answers it
  assign imem_req  = (r_state == S_DROP) || ((r_state == S_FETCH) && (r_count != 2'd2));
  assign imem_addr = (r_state == S_DROP) ? r_drop_addr : r_pc;
  assign w_ack     = imem_req & imem_ack;
  assign w_wr      = (r_count == 2'd1) & ~w_pop;

`ifdef FETCH_DELAY_SLOT_EN
  assign instr_F = (r_count != 2'd0) ? r_instr[0] : 32'd0;
  assign npc_F   = (r_count != 2'd0) ? r_npc[0]   : 32'd0;
`else
  assign instr_F = ((r_count != 2'd0) && !w_redir) ? r_instr[0] : 32'd0;
  assign npc_F   = ((r_count != 2'd0) && !w_redir) ? r_npc[0]   : 32'd0;
`endif
  assign fetch_busy = (r_count == 2'd0);

  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_drop_nx  = r_drop_addr;
    w_push     = 1'b0;
    w_flush    = 1'b0;
`ifdef FETCH_DELAY_SLOT_EN
    w_pend_nx  = r_pend;
    w_tgt_nx   = r_tgt;
`endif
    case (r_state)
      S_IDLE: begin
        w_state_nx = S_FETCH;
        if (w_redir) w_pc_nx = pc_target_D;
      end
      S_FETCH: begin
`ifdef FETCH_DELAY_SLOT_EN
        if (w_redir && (r_count == 2'd0)) begin
          // the word in flight is the delay slot: keep it, retarget after it lands
          if (w_ack) begin
            w_push    = 1'b1;
            w_pc_nx   = pc_target_D;
            w_pend_nx = 1'b0;
          end else begin
            w_pend_nx = 1'b1;
            w_tgt_nx  = pc_target_D;
          end
        end else
`endif
        if (w_redir) begin
          w_flush = 1'b1;
          w_pc_nx = pc_target_D;
          if (imem_req && !imem_ack) begin
            w_state_nx = S_DROP;
            w_drop_nx  = r_pc;
          end
        end else if (w_ack) begin
          w_push  = 1'b1;
          w_pc_nx = w_pc_inc;
`ifdef FETCH_DELAY_SLOT_EN
          if (r_pend) begin
            w_pc_nx   = r_tgt;
            w_pend_nx = 1'b0;
          end
`endif
        end
      end
      S_DROP: begin
        if (w_redir) w_pc_nx = pc_target_D;
        if (imem_ack) w_state_nx = S_FETCH;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_drop_addr <= '0;
`ifdef FETCH_DELAY_SLOT_EN
      r_pend      <= 1'b0;
      r_tgt       <= '0;
`endif
    end else begin
      r_state     <= w_state_nx;
      r_pc        <= w_pc_nx;
      r_drop_addr <= w_drop_nx;
`ifdef FETCH_DELAY_SLOT_EN
      r_pend      <= w_pend_nx;
      r_tgt       <= w_tgt_nx;
`endif
    end
  end

  // Head lives in slot 0; a pop shifts slot 1 down before any push lands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 2'd0;
      r_instr <= '0;
      r_npc   <= '0;
    end else if (w_flush) begin
      r_count <= 2'd0;
    end else begin
      if (w_pop) begin
        r_instr[0] <= r_instr[1];
        r_npc[0]   <= r_npc[1];
      end
      if (w_push) begin
        r_instr[w_wr] <= imem_rdata;
        r_npc[w_wr]   <= w_pc_inc;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a delay-programmable instruction memory responder.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Stall_D = 1'b0;
  logic        PCSrc_D = 1'b0;
  logic [31:0] pc_target_D = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_F;
  logic [31:0] npc_F;
  logic        fetch_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int mem_delay = 0;
  int wcnt = 0;

  fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset(reset), .Stall_D(Stall_D), .PCSrc_D(PCSrc_D),
    .pc_target_D(pc_target_D), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_F(instr_F),
    .npc_F(npc_F), .fetch_busy(fetch_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // memory answers after mem_delay waiting cycles of a held request
  assign imem_ack   = imem_req && (wcnt == mem_delay);
  assign imem_rdata = word_at(imem_addr);
  always @(posedge clk or posedge reset) begin
    if (reset) wcnt <= 0;
    else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic do_reset();
    reset = 1'b1; Stall_D = 1'b0; PCSrc_D = 1'b0; pc_target_D = 32'd0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_delay = 0;
    @(negedge clk); @(negedge clk); #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %h want 0", imem_req); end
    n_cmp++; if (instr_F !== 32'd0) begin n_bad++; $display("FAIL rst_instr: got %h want 0", instr_F); end
    n_cmp++; if (npc_F !== 32'd0) begin n_bad++; $display("FAIL rst_npc: got %h want 0", npc_F); end
    n_cmp++; if (fetch_busy !== 1'b1) begin n_bad++; $display("FAIL rst_busy: got %h want 1", fetch_busy); end
  endtask

  task automatic test_sequential();
    mem_delay = 0;
    do_reset();
    @(negedge clk); #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin n_bad++; $display("FAIL seq_first_req: got %h/%h want 1/00003000", imem_req, imem_addr); end
    n_cmp++; if (fetch_busy !== 1'b1) begin n_bad++; $display("FAIL seq_first_busy: got %h want 1", fetch_busy); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      n_cmp++; if (npc_F !== 32'h3004 + 4*k) begin n_bad++; $display("FAIL seq_npc%0d: got %h want %h", k, npc_F, 32'h3004 + 4*k); end
      n_cmp++; if (instr_F !== word_at(32'h3000 + 4*k)) begin n_bad++; $display("FAIL seq_instr%0d: got %h want %h", k, instr_F, word_at(32'h3000 + 4*k)); end
      n_cmp++; if (imem_addr !== 32'h3004 + 4*k) begin n_bad++; $display("FAIL seq_addr%0d: got %h want %h", k, imem_addr, 32'h3004 + 4*k); end
    end
  endtask

  task automatic test_ack_delay();
    logic [31:0] a;
    mem_delay = 2;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      a = 32'h3000 + 4*k;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk); #1;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== a) begin n_bad++; $display("FAIL dly_addr%0d_%0d: got %h/%h want 1/%h", k, c, imem_req, imem_addr, a); end
        if (c == 0 && k > 0) begin
          n_cmp++; if (fetch_busy !== 1'b0 || instr_F !== word_at(a - 4) || npc_F !== a) begin
            n_bad++; $display("FAIL dly_word%0d: got %h/%h/%h want 0/%h/%h", k - 1, fetch_busy, instr_F, npc_F, word_at(a - 4), a);
          end
        end else begin
          n_cmp++; if (fetch_busy !== 1'b1) begin n_bad++; $display("FAIL dly_busy%0d_%0d: got %h want 1", k, c, fetch_busy); end
        end
      end
    end
    @(negedge clk); #1;
    n_cmp++; if (fetch_busy !== 1'b0 || instr_F !== 32'hA5A5_3008 || npc_F !== 32'h300C) begin
      n_bad++; $display("FAIL dly_word2: got %h/%h/%h want 0/a5a53008/0000300c", fetch_busy, instr_F, npc_F);
    end
  endtask

  task automatic test_stall();
    mem_delay = 0;
    do_reset();
    Stall_D = 1'b1;
    @(negedge clk); @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL stall_req%0d: got %h want 0", c, imem_req); end
      n_cmp++; if (instr_F !== 32'hA5A5_3000) begin n_bad++; $display("FAIL stall_hold%0d: got %h want a5a53000", c, instr_F); end
    end
    @(negedge clk); Stall_D = 1'b0; #1;
    n_cmp++; if (imem_req !== 1'b0 || instr_F !== 32'hA5A5_3000) begin n_bad++; $display("FAIL stall_rel: got %h/%h want 0/a5a53000", imem_req, instr_F); end
    @(negedge clk); #1;
    n_cmp++; if (instr_F !== 32'hA5A5_3004 || npc_F !== 32'h3008) begin n_bad++; $display("FAIL stall_next: got %h/%h want a5a53004/00003008", instr_F, npc_F); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h3008) begin n_bad++; $display("FAIL stall_resume: got %h/%h want 1/00003008", imem_req, imem_addr); end
    @(negedge clk); #1;
    n_cmp++; if (instr_F !== 32'hA5A5_3008 || npc_F !== 32'h300C) begin n_bad++; $display("FAIL stall_order: got %h/%h want a5a53008/0000300c", instr_F, npc_F); end
  endtask

  task automatic test_redirect_drop();
    int n;
    mem_delay = 3;
    do_reset();
    @(negedge clk); PCSrc_D = 1'b1; pc_target_D = 32'h4000; #1;
    n_cmp++; if (instr_F !== 32'd0) begin n_bad++; $display("FAIL drop_kill: got %h want 0", instr_F); end
    @(negedge clk); PCSrc_D = 1'b0; #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin n_bad++; $display("FAIL drop_hold: got %h/%h want 1/00003000", imem_req, imem_addr); end
    @(negedge clk); @(negedge clk); #1;
    n_cmp++; if (imem_ack !== 1'b1 || imem_addr !== 32'h3000) begin n_bad++; $display("FAIL drop_ack: got %h/%h want 1/00003000", imem_ack, imem_addr); end
    @(negedge clk); #1;
`ifdef FETCH_DELAY_SLOT_EN
    n_cmp++; if (npc_F !== 32'h3004 || imem_addr !== 32'h4000) begin n_bad++; $display("FAIL drop_slot: got %h/%h want 00003004/00004000", npc_F, imem_addr); end
`else
    n_cmp++; if (fetch_busy !== 1'b1 || imem_addr !== 32'h4000) begin n_bad++; $display("FAIL drop_discard: got %h/%h want 1/00004000", fetch_busy, imem_addr); end
`endif
    n = 0;
    do begin @(negedge clk); #1; n++; end while (fetch_busy !== 1'b0 && n < 12);
    n_cmp++; if (fetch_busy !== 1'b0) begin n_bad++; $display("FAIL drop_timeout: got busy %h want 0", fetch_busy); end
    n_cmp++; if (npc_F !== 32'h4004 || instr_F !== 32'hA5A5_4000) begin n_bad++; $display("FAIL drop_target: got %h/%h want 00004004/a5a54000", npc_F, instr_F); end
  endtask

  task automatic test_redirect_full();
    mem_delay = 0;
    do_reset();
    Stall_D = 1'b1;
    @(negedge clk); @(negedge clk);
    @(negedge clk); Stall_D = 1'b0; PCSrc_D = 1'b1; pc_target_D = 32'h5000; #1;
`ifdef FETCH_DELAY_SLOT_EN
    n_cmp++; if (instr_F !== 32'hA5A5_3000 || npc_F !== 32'h3004) begin n_bad++; $display("FAIL full_slot: got %h/%h want a5a53000/00003004", instr_F, npc_F); end
`else
    n_cmp++; if (instr_F !== 32'd0 || npc_F !== 32'd0) begin n_bad++; $display("FAIL full_kill: got %h/%h want 0/0", instr_F, npc_F); end
`endif
    @(negedge clk); PCSrc_D = 1'b0; #1;
    n_cmp++; if (fetch_busy !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h5000) begin n_bad++; $display("FAIL full_flush: got %h/%h/%h want 1/1/00005000", fetch_busy, imem_req, imem_addr); end
    @(negedge clk); #1;
    n_cmp++; if (instr_F !== 32'hA5A5_5000 || npc_F !== 32'h5004) begin n_bad++; $display("FAIL full_target: got %h/%h want a5a55000/00005004", instr_F, npc_F); end
  endtask

  task automatic test_wrap_and_stalled_redirect();
    mem_delay = 0;
    do_reset();
    @(negedge clk); PCSrc_D = 1'b1; pc_target_D = 32'hFFFF_FFFC;
    @(negedge clk); PCSrc_D = 1'b0; #1;
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_req: got %h want fffffffc", imem_addr); end
    @(negedge clk); #1;
    n_cmp++; if (imem_addr !== 32'd0) begin n_bad++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
    n_cmp++; if (npc_F !== 32'd0 || instr_F !== 32'h5A5A_FFFC || fetch_busy !== 1'b0) begin n_bad++; $display("FAIL wrap_npc: got %h/%h/%h want 0/5a5afffc/0", npc_F, instr_F, fetch_busy); end
    Stall_D = 1'b1; PCSrc_D = 1'b1; pc_target_D = 32'h6000; #1;
    n_cmp++; if (instr_F !== 32'h5A5A_FFFC) begin n_bad++; $display("FAIL stallredir_kill: got %h want 5a5afffc", instr_F); end
    @(negedge clk); Stall_D = 1'b0; PCSrc_D = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (npc_F !== 32'h4 || instr_F !== 32'hA5A5_0000) begin n_bad++; $display("FAIL stallredir_ignored: got %h/%h want 00000004/a5a50000", npc_F, instr_F); end
  endtask

  task automatic test_reset_mid_request();
    mem_delay = 3;
    do_reset();
    @(negedge clk);
    @(negedge clk); reset = 1'b1; #1;
    n_cmp++; if (imem_req !== 1'b0 || fetch_busy !== 1'b1) begin n_bad++; $display("FAIL midrst_async: got %h/%h want 0/1", imem_req, fetch_busy); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin n_bad++; $display("FAIL midrst_restart: got %h/%h want 1/00003000", imem_req, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_ack_delay();
    test_stall();
    test_redirect_drop();
    test_redirect_full();
    test_wrap_and_stalled_redirect();
    test_reset_mid_request();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
